// File: rtl/apb_completer_pkg.sv
// Shared types for the APB completer: FSM state encoding and the captured response.
package apb_completer_pkg;

  // Width of the captured read data; the completer's DATA_WIDTH must match it.
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic                      err;
    logic [APB_DATA_WIDTH-1:0] data;
  } apb_resp_t;

endpackage

// File: rtl/apb_completer_if.sv
// APB4/5 bus plus the local register request/ack bus, seen from both ends.
interface apb_completer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [2:0]              pprot;
  logic                    pnse;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  logic                    loc_req;
  logic                    loc_write;
  logic [ADDR_WIDTH-1:0]   loc_addr;
  logic [DATA_WIDTH-1:0]   loc_wdata;
  logic [DATA_WIDTH/8-1:0] loc_wstb;
  logic                    loc_ack;
  logic [DATA_WIDTH-1:0]   loc_rdata;
  logic                    loc_err;

  modport slave (
    input  paddr, pprot, pnse, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr,
    output loc_req, loc_write, loc_addr, loc_wdata, loc_wstb,
    input  loc_ack, loc_rdata, loc_err
  );

  modport master (
    output paddr, pprot, pnse, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr,
    input  loc_req, loc_write, loc_addr, loc_wdata, loc_wstb,
    output loc_ack, loc_rdata, loc_err
  );
endinterface

// File: rtl/apb_completer_setup_check.sv
// Combinational screening of an APB setup phase: alignment, window, strobe and privilege.
module apb_completer_setup_check #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH-1:0] SIZE_BYTES = 'h1000,
  parameter bit                    PRIV_ONLY  = 1'b0
) (
  input  logic [ADDR_WIDTH-1:0]   i_paddr,
  input  logic                    i_pwrite,
  input  logic [DATA_WIDTH/8-1:0] i_pstrb,
  input  logic [2:0]              i_pprot,
  output logic                    o_err
);
  localparam int                    LSB      = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] WIN_MASK = ~(SIZE_BYTES - 1'b1);

  logic w_misaligned;
  logic w_outside;
  logic w_bad_strb;
  logic w_unpriv;
  logic w_unused_prot;

  generate
    if (LSB > 0) begin : g_align
      assign w_misaligned = |i_paddr[LSB-1:0];
    end else begin : g_no_align
      assign w_misaligned = 1'b0;
    end
  endgenerate

  // The window is power-of-two sized and aligned, so a masked compare suffices.
  assign w_outside     = (i_paddr & WIN_MASK) != BASE_ADDR;
  assign w_bad_strb    = ~i_pwrite & (|i_pstrb);
  assign w_unpriv      = PRIV_ONLY & ~i_pprot[0];
  assign w_unused_prot = &{1'b0, i_pprot[2:1]};

  assign o_err = w_misaligned | w_outside | w_bad_strb | w_unpriv;
endmodule

// File: rtl/apb_completer.sv
// APB completer: screens setup phases, forwards good ones to the local req/ack bus,
// inserts wait states until ack and aborts with PSLVERR on timeout.
module apb_completer
  import apb_completer_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = APB_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH-1:0] SIZE_BYTES = 'h1000,
  parameter int                    TIMEOUT    = 16,
  parameter bit                    PRIV_ONLY  = 1'b0
) (
  input logic              i_pclk,
  input logic              i_preset,
  apb_completer_if.slave   bus
);
  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_e              r_state, w_state_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_next;
  apb_resp_t               r_resp, w_resp_next;
  logic                    r_loc_req, w_loc_req_next;
  logic                    r_loc_write;
  logic [ADDR_WIDTH-1:0]   r_loc_addr;
  logic [DATA_WIDTH-1:0]   r_loc_wdata;
  logic [DATA_WIDTH/8-1:0] r_loc_wstb;
  logic                    w_load;
  logic                    w_setup_err;
  logic                    w_done;
  logic                    w_unused_pnse;

  assign w_unused_pnse = bus.pnse;

  apb_completer_setup_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .SIZE_BYTES (SIZE_BYTES),
    .PRIV_ONLY  (PRIV_ONLY)
  ) u_setup_check (
    .i_paddr  (bus.paddr),
    .i_pwrite (bus.pwrite),
    .i_pstrb  (bus.pstrb),
    .i_pprot  (bus.pprot),
    .o_err    (w_setup_err)
  );

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_resp_next    = r_resp;
    w_loc_req_next = r_loc_req;
    w_load         = 1'b0;
    w_done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          w_cnt_next = '0;
          if (w_setup_err) begin
            w_resp_next  = '{err: 1'b1, data: '0};
            w_state_next = RESP;
          end else begin
            w_load         = 1'b1;
            w_loc_req_next = 1'b1;
            w_state_next   = REQ;
          end
        end
      end
      REQ, DRAIN: begin
        if (bus.loc_ack) begin
          w_done           = 1'b1;
          w_resp_next.err  = bus.loc_err;
          w_resp_next.data = r_loc_write ? '0 : APB_DATA_WIDTH'(bus.loc_rdata);
        end else if (r_cnt == CNT_LAST) begin
          w_done      = 1'b1;
          w_resp_next = '{err: 1'b1, data: '0};
        end else begin
          w_cnt_next = r_cnt + 1'b1;
          if (r_state == REQ && !bus.psel) begin
            w_state_next = DRAIN;
          end
        end
        // An abandoned transfer owes no APB response once the local side finishes.
        if (w_done) begin
          w_loc_req_next = 1'b0;
          w_state_next   = (r_state == REQ && bus.psel) ? RESP : IDLE;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_resp      <= '0;
      r_loc_req   <= 1'b0;
      r_loc_write <= 1'b0;
      r_loc_addr  <= '0;
      r_loc_wdata <= '0;
      r_loc_wstb  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_resp    <= w_resp_next;
      r_loc_req <= w_loc_req_next;
      if (w_load) begin
        r_loc_write <= bus.pwrite;
        r_loc_addr  <= bus.paddr - BASE_ADDR;
        r_loc_wdata <= bus.pwdata;
        r_loc_wstb  <= bus.pwrite ? bus.pstrb : '0;
      end
    end
  end

  assign bus.pready    = (r_state == RESP);
  assign bus.pslverr   = (r_state == RESP) && r_resp.err;
  assign bus.prdata    = (r_state == RESP && !r_resp.err) ? DATA_WIDTH'(r_resp.data) : '0;
  assign bus.loc_req   = r_loc_req;
  assign bus.loc_write = r_loc_write;
  assign bus.loc_addr  = r_loc_addr;
  assign bus.loc_wdata = r_loc_wdata;
  assign bus.loc_wstb  = r_loc_wstb;
endmodule

// File: tb/tb_apb_completer.sv
// Directed bench for apb_completer: stimulus pushes expectations, monitor and local responder check.
module tb_apb_completer;
  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam logic [31:0] SIZE = 32'h0000_1000;
  localparam int          TO   = 16;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
  } apb_exp_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    int          ack_at;
    logic [31:0] rdata;
    logic        err;
    int          len;
  } loc_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_completer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_completer #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BASE_ADDR  (BASE),
    .SIZE_BYTES (SIZE),
    .TIMEOUT    (TO),
    .PRIV_ONLY  (1'b0)
  ) dut (
    .i_pclk   (clk),
    .i_preset (rst),
    .bus      (bus)
  );

  apb_exp_t apb_q[$];
  loc_exp_t loc_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_loc(input logic wr, input logic [31:0] laddr, input logic [31:0] wdata,
                          input logic [3:0] wstb, input int ack_at, input logic [31:0] l_rdata,
                          input logic l_err, input int len);
    loc_exp_t l;
    l = '{wr, laddr, wdata, wstb, ack_at, l_rdata, l_err, len};
    loc_q.push_back(l);
  endtask

  task automatic drive_setup(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                             input logic [3:0] strb);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.paddr   = addr;
    bus.pwrite  = wr;
    bus.pwdata  = wdata;
    bus.pstrb   = strb;
    bus.pprot   = 3'b000;
  endtask

  task automatic release_bus();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.pstrb   = 4'h0;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the completing edge.
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [31:0] exp_data, input logic exp_err,
                          input int exp_acc, input bit has_loc, input logic [31:0] exp_laddr,
                          input logic [3:0] exp_wstb, input int ack_at, input logic [31:0] l_rdata,
                          input logic l_err, input int exp_len);
    apb_exp_t e;
    int n;
    e = '{exp_data, exp_err, exp_acc};
    apb_q.push_back(e);
    if (has_loc) push_loc(wr, exp_laddr, wdata, exp_wstb, ack_at, l_rdata, l_err, exp_len);
    drive_setup(addr, wr, wdata, strb);
    @(posedge clk); #1;
    bus.penable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.pready && n < 64);
    if (!bus.pready) check("pready_timeout", 32'(bus.pready), 32'd1);
    @(posedge clk); #1;
    release_bus();
  endtask

  // APB monitor: pops an expectation whenever pready is seen.
  initial begin : monitor
    int acc;
    apb_exp_t e;
    acc = 0;
    forever begin
      @(negedge clk);
      if (rst || !bus.psel) acc = 0;
      else if (bus.penable) acc++;
      if (bus.pready) begin
        if (apb_q.size() == 0) begin
          check("unexpected_pready", 32'(bus.pready), 32'd0);
        end else begin
          e = apb_q.pop_front();
          $display("apb resp: prdata=%h pslverr=%0d access_cycles=%0d", bus.prdata, bus.pslverr, acc);
          check("prdata", bus.prdata, e.data);
          check("pslverr", 32'(bus.pslverr), 32'(e.err));
          check("access_cycles", acc, e.acc);
        end
        acc = 0;
      end
    end
  end

  // Local-side responder: checks the request fields and acks at the scripted cycle.
  initial begin : responder
    int cnt;
    bit have;
    loc_exp_t c;
    cnt  = 0;
    have = 1'b0;
    c    = '{1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 0};
    bus.loc_ack   = 1'b0;
    bus.loc_rdata = 32'h0;
    bus.loc_err   = 1'b0;
    forever begin
      @(negedge clk);
      bus.loc_ack   = 1'b0;
      bus.loc_rdata = 32'h0;
      bus.loc_err   = 1'b0;
      if (bus.loc_req) begin
        if (cnt == 0) begin
          if (loc_q.size() == 0) begin
            check("unexpected_loc_req", 32'(bus.loc_req), 32'd0);
            have = 1'b0;
          end else begin
            c    = loc_q.pop_front();
            have = 1'b1;
            $display("loc req: write=%0d addr=%h wdata=%h wstb=%h", bus.loc_write, bus.loc_addr, bus.loc_wdata, bus.loc_wstb);
            check("loc_write", 32'(bus.loc_write), 32'(c.write));
            check("loc_addr", bus.loc_addr, c.addr);
            check("loc_wdata", bus.loc_wdata, c.wdata);
            check("loc_wstb", 32'(bus.loc_wstb), 32'(c.wstb));
          end
        end
        cnt++;
        if (have && c.ack_at == cnt) begin
          bus.loc_ack   = 1'b1;
          bus.loc_rdata = c.rdata;
          bus.loc_err   = c.err;
        end
      end else begin
        if (cnt > 0 && have && c.len > 0) check("loc_req_cycles", cnt, c.len);
        cnt  = 0;
        have = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.paddr   = 32'h0;
    bus.pprot   = 3'b000;
    bus.pnse    = 1'b0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.pwdata  = 32'h0;
    bus.pstrb   = 4'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pready", 32'(bus.pready), 32'd0);
    check("rst_pslverr", 32'(bus.pslverr), 32'd0);
    check("rst_prdata", bus.prdata, 32'h0);
    check("rst_loc_req", 32'(bus.loc_req), 32'd0);
    check("rst_loc_write", 32'(bus.loc_write), 32'd0);
    check("rst_loc_addr", bus.loc_addr, 32'h0);
    check("rst_loc_wdata", bus.loc_wdata, 32'h0);
    check("rst_loc_wstb", 32'(bus.loc_wstb), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // addr, wr, wdata, strb, exp_data, exp_err, exp_acc, has_loc, laddr, wstb, ack_at, l_rdata, l_err, len
    apb_xfer(BASE + 32'h4, 1'b1, 32'hA5A5_0001, 4'hF, 32'h0, 1'b0, 2, 1'b1, 32'h4, 4'hF, 1, 32'h0, 1'b0, 1);
    idle(2);
    apb_xfer(BASE + 32'h8, 1'b0, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 4, 1'b1, 32'h8, 4'h0, 3, 32'h1234_5678, 1'b0, 3);
    idle(1);
    apb_xfer(BASE + SIZE, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 0);
    apb_xfer(BASE + 32'h2, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 0);
    apb_xfer(BASE + 32'h8, 1'b0, 32'h0, 4'h1, 32'h0, 1'b1, 1, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 0);
    apb_xfer(BASE - 32'h4, 1'b1, 32'h1111_2222, 4'hF, 32'h0, 1'b1, 1, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 0);
    idle(1);
    // No ack: loc_req held TIMEOUT cycles, response in the following access cycle.
    apb_xfer(BASE + 32'hC, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 17, 1'b1, 32'hC, 4'h0, 0, 32'h0, 1'b0, 16);
    idle(1);
    // Local error on a read, then a back-to-back write.
    apb_xfer(BASE + 32'h10, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 3, 1'b1, 32'h10, 4'h0, 2, 32'hDEAD_BEEF, 1'b1, 2);
    apb_xfer(BASE + 32'h14, 1'b1, 32'h0BAD_F00D, 4'h3, 32'h0, 1'b0, 2, 1'b1, 32'h14, 4'h3, 1, 32'h0, 1'b0, 1);
    idle(2);

    // Reset in the middle of REQ clears loc_req without waiting for a clock edge.
    push_loc(1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h0, 1'b0, 0);
    drive_setup(BASE + 32'h20, 1'b0, 32'h0, 4'h0);
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    check("req_before_reset", 32'(bus.loc_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("loc_req_async_clear", 32'(bus.loc_req), 32'd0);
    release_bus();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Requester drops psel mid-REQ: drain the local access, never answer on APB.
    push_loc(1'b0, 32'h24, 32'h0, 4'h0, 4, 32'h5555_AAAA, 1'b0, 4);
    drive_setup(BASE + 32'h24, 1'b0, 32'h0, 4'h0);
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    release_bus();
    repeat (6) begin
      @(negedge clk);
      check("drain_no_pready", 32'(bus.pready), 32'd0);
    end
    check("drain_released", 32'(bus.loc_req), 32'd0);
    @(posedge clk); #1;

    apb_xfer(BASE + 32'hFFC, 1'b0, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0, 3, 1'b1, 32'hFFC, 4'h0, 2, 32'hCAFE_0001, 1'b0, 2);
    idle(3);
    check("apb_q_drained", apb_q.size(), 32'd0);
    check("loc_q_drained", loc_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
